pattern_detector_prog: RTL and testbench

//  Programmable serial pattern detector; next-generation successor of the fixed 3-bit detector.

---
 rtl/pattern_detector_pkg.sv | 21 ++
 rtl/pattern_shift_window.sv | 49 ++++
 rtl/pattern_detector_prog.sv | 104 ++++++++++
 tb/tb_pattern_detector_prog.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_detector_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package pattern_detector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_e;

  localparam logic OVERLAP_DEFAULT = 1'b1;

  // Largest value a counter of the given width can hold (widths up to 32).
  function automatic logic [31:0] sat_max(input int unsigned width);
    if (width >= 32'd32) begin
      return 32'hFFFF_FFFF;
    end else begin
      return (32'd1 << width) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/pattern_shift_window.sv
// Serial-in window (newest bit at the MSB) with a fill counter that saturates at PAT_W.
module pattern_shift_window #(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             shift_en,
  input  logic             fill_clr,
  input  logic             bit_in,
  output logic [PAT_W-1:0] win_next,
  output logic             full_next
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ONE = {{(FILL_W-1){1'b0}}, 1'b1};

  logic [PAT_W-1:0]  win_r;
  logic [FILL_W-1:0] fill_r;

  // Next window value and whether the bit sampled this edge completes the window.
  always_comb begin
    if (shift_en) begin
      win_next  = {bit_in, win_r[PAT_W-1:1]};
      full_next = (fill_r >= (FILL_MAX - FILL_ONE));
    end else begin
      win_next  = win_r;
      full_next = 1'b0;
    end
  end

  // Window shift register and saturating fill count; a clear wins over counting.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      win_r  <= {PAT_W{1'b0}};
      fill_r <= {FILL_W{1'b0}};
    end else begin
      if (shift_en) begin
        win_r <= win_next;
      end
      if (fill_clr) begin
        fill_r <= {FILL_W{1'b0}};
      end else if (shift_en && (fill_r != FILL_MAX)) begin
        fill_r <= fill_r + FILL_ONE;
      end
    end
  end

endmodule

// File: rtl/pattern_detector_prog.sv
// Programmable serial pattern detector: masked compare over a PAT_W window,
// overlapping/non-overlapping modes and a saturating match counter.
module pattern_detector_prog
  import pattern_detector_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             enable,
  input  logic             serial_pattern,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  input  logic             count_clear,
  output logic             pattern_detected,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [31:0]      CNT_MAX_W = sat_max(CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_MAX_W[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_r;
  logic [PAT_W-1:0] pat_r;
  logic [PAT_W-1:0] mask_r;
  logic             overlap_r;
  logic             det_r;
  logic [CNT_W-1:0] cnt_r;

  logic [PAT_W-1:0] win_next_s;
  logic             full_next_s;
  logic             shift_s;
  logic             legal_s;
  logic             hit_s;
  logic             match_s;
  logic             fill_clr_s;

  pattern_shift_window #(
    .PAT_W (PAT_W)
  ) u_window (
    .clk       (clk),
    .rstb      (rstb),
    .shift_en  (shift_s),
    .fill_clr  (fill_clr_s),
    .bit_in    (serial_pattern),
    .win_next  (win_next_s),
    .full_next (full_next_s)
  );

  // A load edge discards its bit; a non-overlapping hit forces a fresh window.
  always_comb begin
    shift_s    = enable & ~cfg_load;
    legal_s    = (state_r == ARMED) | full_next_s;
    hit_s      = (((win_next_s ^ pat_r) & mask_r) == {PAT_W{1'b0}}) &
                 (mask_r != {PAT_W{1'b0}});
    match_s    = shift_s & legal_s & hit_s;
    fill_clr_s = ~enable | cfg_load | (match_s & ~overlap_r);
  end

  // Control FSM, configuration shadow registers and the registered detect.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r   <= IDLE;
      pat_r     <= {PAT_W{1'b0}};
      mask_r    <= {PAT_W{1'b0}};
      overlap_r <= OVERLAP_DEFAULT;
      det_r     <= 1'b0;
    end else begin
      det_r <= match_s;
      if (cfg_load) begin
        pat_r     <= cfg_pattern;
        mask_r    <= cfg_mask;
        overlap_r <= cfg_overlap;
      end
      if (!enable) begin
        state_r <= IDLE;
      end else if (cfg_load || (match_s && !overlap_r)) begin
        state_r <= FILL;
      end else if (full_next_s) begin
        state_r <= ARMED;
      end else begin
        state_r <= FILL;
      end
    end
  end

  // Saturating match counter; a clear still counts a match on the same edge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (count_clear) begin
      cnt_r <= {{(CNT_W-1){1'b0}}, match_s};
    end else if (match_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign pattern_detected = det_r & enable;
  assign match_count      = cnt_r;

endmodule

// File: tb/tb_pattern_detector_prog.sv
// Directed bench for pattern_detector_prog: a 3-bit/2-bit-counter instance and an
// 8-bit/16-bit-counter instance, each checked every cycle against a queue-based model.
module tb_pattern_detector_prog;

  logic        clk = 1'b0;
  logic        rstb;
  logic        en3, en8, sbit, ld3, ld8, clr3, clr8, ov3, ov8;
  logic [2:0]  p3, m3;
  logic [7:0]  p8, m8;
  logic        pd3, pd8;
  logic [1:0]  cnt3;
  logic [15:0] cnt8;

  int n_cmp = 0;
  int n_bad = 0;

  pattern_detector_prog #(.PAT_W(3), .CNT_W(2)) u3 (
    .clk(clk), .rstb(rstb), .enable(en3), .serial_pattern(sbit), .cfg_load(ld3),
    .cfg_pattern(p3), .cfg_mask(m3), .cfg_overlap(ov3), .count_clear(clr3),
    .pattern_detected(pd3), .match_count(cnt3)
  );

  pattern_detector_prog #(.PAT_W(8), .CNT_W(16)) u8 (
    .clk(clk), .rstb(rstb), .enable(en8), .serial_pattern(sbit), .cfg_load(ld8),
    .cfg_pattern(p8), .cfg_mask(m8), .cfg_overlap(ov8), .count_clear(clr8),
    .pattern_detected(pd8), .match_count(cnt8)
  );

  always #5 clk = ~clk;

  // Reference model: history of sampled bits since the last restart.
  bit         q3[$];
  bit         q8[$];
  logic [2:0] mp3 = 3'd0, mm3 = 3'd0;
  logic [7:0] mp8 = 8'd0, mm8 = 8'd0;
  bit         mo3 = 1'b1, mo8 = 1'b1, md3 = 1'b0, md8 = 1'b0;
  int         mc3 = 0, mc8 = 0;

  function automatic bit hit(input bit q[$], input int w, input logic [7:0] pat,
                             input logic [7:0] mask);
    if (q.size() < w || mask == 8'd0) return 1'b0;
    for (int i = 0; i < w; i++) begin
      if (mask[i] && (q[q.size() - w + i] != pat[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rstb);
      if (!rstb) begin
        q3.delete(); q8.delete();
        mp3 = 3'd0; mm3 = 3'd0; mo3 = 1'b1; md3 = 1'b0; mc3 = 0;
        mp8 = 8'd0; mm8 = 8'd0; mo8 = 1'b1; md8 = 1'b0; mc8 = 0;
      end else begin
        if (ld3) begin mp3 = p3; mm3 = m3; mo3 = ov3; end
        if (!en3 || ld3) begin
          q3.delete(); md3 = 1'b0;
        end else begin
          q3.push_back(sbit);
          if (q3.size() > 8) void'(q3.pop_front());
          md3 = hit(q3, 3, {5'd0, mp3}, {5'd0, mm3});
          if (md3 && !mo3) q3.delete();
        end
        if (clr3) mc3 = md3 ? 1 : 0;
        else if (md3 && mc3 < 3) mc3++;

        if (ld8) begin mp8 = p8; mm8 = m8; mo8 = ov8; end
        if (!en8 || ld8) begin
          q8.delete(); md8 = 1'b0;
        end else begin
          q8.push_back(sbit);
          if (q8.size() > 8) void'(q8.pop_front());
          md8 = hit(q8, 8, mp8, mm8);
          if (md8 && !mo8) q8.delete();
        end
        if (clr8) mc8 = md8 ? 1 : 0;
        else if (md8 && mc8 < 65535) mc8++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_pd3", 32'(pd3), 32'(md3 & en3 & rstb));
    chk("cyc_cnt3", 32'(cnt3), rstb ? 32'(mc3) : 32'd0);
    chk("cyc_pd8", 32'(pd8), 32'(md8 & en8 & rstb));
    chk("cyc_cnt8", 32'(cnt8), rstb ? 32'(mc8) : 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
    ld3 = 1'b0; ld8 = 1'b0; clr3 = 1'b0; clr8 = 1'b0;
  endtask

  task automatic bit3(input logic b);
    en3 = 1'b1; en8 = 1'b0; sbit = b; tick();
  endtask

  task automatic bit8(input logic b);
    en8 = 1'b1; en3 = 1'b0; sbit = b; tick();
  endtask

  // Streams n bits of v, oldest (leftmost) first.
  task automatic bits8(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit8(v[i]);
  endtask

  task automatic load3(input logic [2:0] pat, input logic [2:0] mask, input logic ov);
    p3 = pat; m3 = mask; ov3 = ov; ld3 = 1'b1; en3 = 1'b1; en8 = 1'b0; sbit = 1'b1; tick();
  endtask

  task automatic load8(input logic [7:0] pat, input logic [7:0] mask, input logic ov);
    p8 = pat; m8 = mask; ov8 = ov; ld8 = 1'b1; en8 = 1'b1; en3 = 1'b0; sbit = 1'b1; tick();
  endtask

  initial begin
    rstb = 1'b0; en3 = 1'b0; en8 = 1'b0; sbit = 1'b0;
    ld3 = 1'b0; ld8 = 1'b0; clr3 = 1'b0; clr8 = 1'b0;
    p3 = 3'd0; m3 = 3'd0; ov3 = 1'b1; p8 = 8'd0; m8 = 8'd0; ov8 = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pd3", 32'(pd3), 32'd0);
    chk("rst_pd8", 32'(pd8), 32'd0);
    chk("rst_cnt3", 32'(cnt3), 32'd0);
    chk("rst_cnt8", 32'(cnt8), 32'd0);
    rstb = 1'b1;

    // 3-bit overlapping detect of 3'b011 (oldest-first 1,1,0).
    load3(3'b011, 3'b111, 1'b1);
    bit3(1'b1); bit3(1'b1); bit3(1'b0);
    chk("t1_bit3", 32'(pd3), 32'd1);
    bit3(1'b1);
    chk("t1_bit4", 32'(pd3), 32'd0);
    bit3(1'b1);
    chk("t1_bit5", 32'(pd3), 32'd0);
    bit3(1'b0);
    chk("t1_bit6", 32'(pd3), 32'd1);
    chk("t1_cnt", 32'(cnt3), 32'd2);

    // 2-bit counter saturation, then clear with and without a match.
    for (int k = 0; k < 3; k++) begin
      bit3(1'b1); bit3(1'b1); bit3(1'b0);
    end
    chk("t6_sat", 32'(cnt3), 32'd3);
    bit3(1'b1); bit3(1'b1);
    clr3 = 1'b1; bit3(1'b0);
    chk("t6_clr_match", 32'(cnt3), 32'd1);
    chk("t6_clr_pd", 32'(pd3), 32'd1);
    clr3 = 1'b1; bit3(1'b1);
    chk("t6_clr_alone", 32'(cnt3), 32'd0);
    bit3(1'b1); bit3(1'b0);
    chk("t6_recount", 32'(cnt3), 32'd1);

    // 8'hA5 on a period-5 stream: non-overlap sees one hit, overlap two.
    load8(8'hA5, 8'hFF, 1'b0);
    bits8(32'b1010010, 7);
    chk("t2_no_early", 32'(pd8), 32'd0);
    bit8(1'b1);
    chk("t2_first", 32'(pd8), 32'd1);
    bits8(32'b00101, 5);
    chk("t2_nonov_pd", 32'(pd8), 32'd0);
    chk("t2_nonov_cnt", 32'(cnt8), 32'd1);
    load8(8'hA5, 8'hFF, 1'b1);
    bits8(32'b1010010100101, 13);
    chk("t2_ov_pd", 32'(pd8), 32'd1);
    chk("t2_ov_cnt", 32'(cnt8), 32'd3);

    // Low-nibble mask, then an all-zero mask that never matches.
    load8(8'h35, 8'h0F, 1'b1);
    bits8(32'b10101111, 8);
    chk("t3_nibble", 32'(pd8), 32'd1);
    chk("t3_cnt", 32'(cnt8), 32'd4);
    load8(8'h00, 8'h00, 1'b1);
    bits8(32'd0, 12);
    chk("t3_mask0_pd", 32'(pd8), 32'd0);
    chk("t3_mask0_cnt", 32'(cnt8), 32'd4);

    // Enable drop: detect gated at once, window must refill afterwards.
    load8(8'hA5, 8'hFF, 1'b1);
    bits8(32'b10100101, 8);
    chk("t4_pre", 32'(pd8), 32'd1);
    en8 = 1'b0;
    #1;
    chk("t4_gate", 32'(pd8), 32'd0);
    tick(); tick();
    chk("t4_idle", 32'(pd8), 32'd0);
    bits8(32'b00101, 5);
    chk("t4_refill", 32'(pd8), 32'd0);
    bits8(32'b00101, 5);
    chk("t4_rematch", 32'(pd8), 32'd1);
    chk("t4_cnt", 32'(cnt8), 32'd6);

    // Load on the edge that would complete a match.
    bits8(32'b0010, 4);
    load8(8'hFF, 8'hFF, 1'b1);
    chk("t5_load_edge", 32'(pd8), 32'd0);
    bits8(32'h7F, 7);
    chk("t5_seven", 32'(pd8), 32'd0);
    bit8(1'b1);
    chk("t5_newpat", 32'(pd8), 32'd1);
    chk("t5_cnt", 32'(cnt8), 32'd7);

    // Asynchronous reset between clock edges.
    #1;
    rstb = 1'b0;
    #1;
    chk("ar_pd8", 32'(pd8), 32'd0);
    chk("ar_cnt8", 32'(cnt8), 32'd0);
    chk("ar_cnt3", 32'(cnt3), 32'd0);
    @(posedge clk);
    #2;
    rstb = 1'b1;
    bits8(32'h3FF, 10);
    chk("post_rst_nomatch", 32'(pd8), 32'd0);
    load8(8'hA5, 8'hFF, 1'b1);
    bits8(32'b10100101, 8);
    chk("post_rst_pd", 32'(pd8), 32'd1);
    chk("post_rst_cnt", 32'(cnt8), 32'd1);
    en8 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
